// File: rtl/pad_remover.sv
// pad_remover: strips the PAD-wide zero border from a padded raster stream.
// Upstream beats arrive in raster order over a (IMG_W+2*PAD) x (IMG_H+2*PAD)
// frame. Border beats are always accepted and dropped. Interior beats are
// forwarded through a one-entry output register with row/frame markers.
// Framing is purely by beat count; there is no error detection.

module pad_remover #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int PAD    = 1,
    localparam int PW    = IMG_W + 2 * PAD,
    localparam int PH    = IMG_H + 2 * PAD,
    localparam int CW    = (PW > 1) ? $clog2(PW) : 1,
    localparam int RW    = (PH > 1) ? $clog2(PH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done,
    output logic [CW-1:0]     col,
    output logic [RW-1:0]     row
);

    // Raster landmarks, expressed at the width of the position counters.
    localparam logic [CW-1:0] COL_LO  = CW'(PAD);
    localparam logic [CW-1:0] COL_HI  = CW'(PAD + IMG_W - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(PW - 1);
    localparam logic [RW-1:0] ROW_LO  = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI  = RW'(PAD + IMG_H - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(PH - 1);

    // Registered state.
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_eol_r;
    logic              out_eof_r;
    logic              frame_done_r;

    // Combinational decode of the current position and handshakes.
    logic          col_in_s;
    logic          row_in_s;
    logic          interior_s;
    logic          col_wrap_s;
    logic          row_wrap_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          load_s;
    logic          drain_s;
    logic          last_beat_s;
    logic          eol_s;
    logic          eof_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic          out_valid_nxt_s;

    // Classify the position of the next upstream beat (interior vs border).
    always_comb begin
        col_in_s   = (col_r >= COL_LO) && (col_r <= COL_HI);
        row_in_s   = (row_r >= ROW_LO) && (row_r <= ROW_HI);
        interior_s = col_in_s && row_in_s;
        col_wrap_s = (col_r == COL_MAX);
        row_wrap_s = (row_r == ROW_MAX);
        eol_s      = (col_r == COL_HI);
        eof_s      = (col_r == COL_HI) && (row_r == ROW_HI);
    end

    // Upstream ready: border always drains, interior waits for a free output slot.
    // Depends only on registered position/out_valid and downstream ready.
    always_comb begin
        if (!en) begin
            in_ready_s = 1'b0;
        end else if (!interior_s) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = !out_valid_r || out_ready;
        end
    end

    // Handshake events for this cycle.
    always_comb begin
        accept_s    = in_valid && in_ready_s;
        load_s      = accept_s && interior_s;
        drain_s     = out_valid_r && out_ready;
        last_beat_s = accept_s && col_wrap_s && row_wrap_s;
    end

    // Next raster position: column wraps every PW beats, row wraps every frame.
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (accept_s) begin
            if (col_wrap_s) begin
                col_nxt_s = {CW{1'b0}};
                if (row_wrap_s) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = row_r + RW'(1);
                end
            end else begin
                col_nxt_s = col_r + CW'(1);
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Output-slot occupancy: a new load wins over a drain in the same cycle.
    always_comb begin
        case ({load_s, drain_s})
            2'b10, 2'b11: out_valid_nxt_s = 1'b1;
            2'b01:        out_valid_nxt_s = 1'b0;
            2'b00:        out_valid_nxt_s = out_valid_r;
            default:      out_valid_nxt_s = 1'b0;
        endcase
    end

    // Position counters and completion pulse; en low flushes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            frame_done_r <= 1'b0;
        end else if (!en) begin
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            frame_done_r <= last_beat_s;
        end
    end

    // Output valid and markers; en low drops any held pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_eol_r   <= 1'b0;
            out_eof_r   <= 1'b0;
        end else if (!en) begin
            out_valid_r <= 1'b0;
            out_eol_r   <= 1'b0;
            out_eof_r   <= 1'b0;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            if (load_s) begin
                out_eol_r <= eol_s;
                out_eof_r <= eof_s;
            end else begin
                out_eol_r <= out_eol_r;
                out_eof_r <= out_eof_r;
            end
        end
    end

    // Output pixel: only cleared by reset, held across en-low flushes and stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r <= {DATA_W{1'b0}};
        end else if (en && load_s) begin
            out_data_r <= in_data;
        end else begin
            out_data_r <= out_data_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_eol    = out_eol_r;
    assign out_eof    = out_eof_r;
    assign frame_done = frame_done_r;
    assign col        = col_r;
    assign row        = row_r;

endmodule

// File: tb/tb_pad_remover.sv
// Testbench for pad_remover with a 4x3 interior and a 1-pixel border.
// A frame-level model (beat counter + queue of pending interior pixels)
// predicts every output; literal sequences pin the model itself.

module tb_pad_remover;

    localparam int DW    = 8;
    localparam int IW    = 4;
    localparam int IH    = 3;
    localparam int PD    = 1;
    localparam int PW    = IW + 2 * PD;
    localparam int PH    = IH + 2 * PD;
    localparam int FRAME = PW * PH;
    localparam int CW    = $clog2(PW);
    localparam int RW    = $clog2(PH);

    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_TOGGLE = 2;

    logic          clk;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_eol;
    logic          out_eof;
    logic          frame_done;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    pad_remover #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .PAD(PD)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .frame_done(frame_done),
        .col       (col),
        .row       (row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int data;
        bit eol;
        bit eof;
    } pix_t;

    // Model state.
    pix_t pend_q[$];
    int   k_beat   = 0;
    bit   exp_fd   = 1'b0;
    int   recv_q[$];
    int   n_eol    = 0;
    int   n_eof    = 0;
    int   n_fd     = 0;
    int   base_seq[12] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_interior(input int k);
        int r;
        int c;
        r = k / PW;
        c = k % PW;
        return (r >= PD) && (r < PD + IH) && (c >= PD) && (c < PD + IW);
    endfunction

    // Compare-and-advance process: checks outputs, then predicts the coming edge.
    initial begin
        pix_t p;
        bit   exp_rdy;
        bit   acc;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_out_data", int'(out_data), 0);
                chk("rst_out_eol", int'(out_eol), 0);
                chk("rst_out_eof", int'(out_eof), 0);
                chk("rst_frame_done", int'(frame_done), 0);
                chk("rst_row", int'(row), 0);
                chk("rst_col", int'(col), 0);
                chk("rst_in_ready", int'(in_ready), int'(en));
                pend_q.delete();
                k_beat = 0;
                exp_fd = 1'b0;
            end else begin
                chk("row", int'(row), k_beat / PW);
                chk("col", int'(col), k_beat % PW);
                chk("out_valid", int'(out_valid), int'(pend_q.size() != 0));
                chk("frame_done", int'(frame_done), int'(exp_fd));
                if (frame_done) n_fd++;
                if (pend_q.size() != 0) begin
                    chk("out_data", int'(out_data), pend_q[0].data);
                    chk("out_eol", int'(out_eol), int'(pend_q[0].eol));
                    chk("out_eof", int'(out_eof), int'(pend_q[0].eof));
                end
                exp_rdy = en && (!is_interior(k_beat) || pend_q.size() == 0 || out_ready);
                chk("in_ready", int'(in_ready), int'(exp_rdy));
                if (!en) begin
                    pend_q.delete();
                    k_beat = 0;
                    exp_fd = 1'b0;
                end else begin
                    if (pend_q.size() != 0 && out_ready) begin
                        p = pend_q.pop_front();
                        recv_q.push_back(p.data);
                        if (p.eol) n_eol++;
                        if (p.eof) n_eof++;
                    end
                    acc    = in_valid && exp_rdy;
                    exp_fd = acc && (k_beat == FRAME - 1);
                    if (acc) begin
                        if (is_interior(k_beat)) begin
                            p.data = int'(in_data);
                            p.eol  = (k_beat % PW) == PD + IW - 1;
                            p.eof  = p.eol && ((k_beat / PW) == PD + IH - 1);
                            pend_q.push_back(p);
                        end
                        k_beat = (k_beat + 1) % FRAME;
                    end
                end
            end
        end
    end

    // Drive nbeats raster beats (data = raster index within frame); call at posedge+1.
    task automatic drive(input int nbeats, input int mode);
        int  b;
        int  cyc;
        bit  acc;
        b   = 0;
        cyc = 0;
        while (b < nbeats && cyc < 300) begin
            in_valid  = (mode == M_TOGGLE) ? (cyc % 2 == 0) : 1'b1;
            in_data   = DW'(b % FRAME);
            out_ready = (mode == M_STALL && cyc >= 8 && cyc <= 12) ? 1'b0 : 1'b1;
            #3;
            acc = in_valid && in_ready;
            if (mode == M_STALL && cyc == 10) begin
                chk("stall_hold_valid", int'(out_valid), 1);
                chk("stall_hold_data", int'(out_data), 7);
            end
            @(posedge clk);
            #1;
            if (acc) b++;
            cyc++;
        end
        if (b < nbeats) chk("drive_timeout", b, nbeats);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Let the output register empty, bounded.
    task automatic drain();
        int n;
        n = 0;
        while (pend_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", int'(pend_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        recv_q.delete();
        n_eol = 0;
        n_eof = 0;
        n_fd  = 0;
    endtask

    // Literal expectations for nframes complete frames.
    task automatic check_frames(input string tag, input int nframes);
        chk({tag, "_count"}, recv_q.size(), 12 * nframes);
        for (int i = 0; i < recv_q.size() && i < 12 * nframes; i++) begin
            chk({tag, "_seq"}, recv_q[i], base_seq[i % 12]);
        end
        chk({tag, "_eol"}, n_eol, 3 * nframes);
        chk({tag, "_eof"}, n_eof, nframes);
        chk({tag, "_frame_done"}, n_fd, nframes);
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;

        clear_stats();
        drive(FRAME, M_NORMAL);
        drain();
        check_frames("basic", 1);

        clear_stats();
        drive(FRAME, M_STALL);
        drain();
        check_frames("stall", 1);

        clear_stats();
        drive(FRAME, M_TOGGLE);
        drain();
        check_frames("toggle", 1);

        clear_stats();
        drive(2 * FRAME, M_NORMAL);
        drain();
        check_frames("b2b", 2);

        // Reset after beat 15, then a clean frame.
        clear_stats();
        drive(16, M_NORMAL);
        reset = 1'b1;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_row", int'(row), 0);
        chk("post_rst_col", int'(col), 0);
        clear_stats();
        drive(FRAME, M_NORMAL);
        drain();
        check_frames("after_reset", 1);

        // en flush mid-frame, then a clean frame.
        clear_stats();
        drive(10, M_NORMAL);
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        chk("flush_row", int'(row), 0);
        chk("flush_col", int'(col), 0);
        chk("flush_valid", int'(out_valid), 0);
        clear_stats();
        drive(FRAME, M_NORMAL);
        drain();
        check_frames("after_flush", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
